sipo_stream_packer: RTL and testbench

//  Parametrised serial-in/parallel-out packer. Accepts WORD_W-bit words over a valid/ready

---
 rtl/sipo_stream_packer.sv | 116 +++++++++++
 tb/tb_sipo_stream_packer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_stream_packer.sv
// Serial-in/parallel-out stream packer: DEPTH words of WORD_W bits form one frame, with a
// backpressured output holding register. Define SIPO_FLUSH_EN to add the partial-frame flush port.
module sipo_stream_packer #(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned DEPTH  = 8,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WORD_W-1:0]       in_data,
   input  logic                    msb_first,
`ifdef SIPO_FLUSH_EN
   input  logic                    flush,
`endif
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DEPTH*WORD_W-1:0] out_data,
   output logic [CNT_W-1:0]        out_words,
   output logic [CNT_W-1:0]        fill_cnt,
   output logic                    frame_done
);

   localparam logic [CNT_W-1:0] Full = CNT_W'(DEPTH);

   logic [WORD_W-1:0]       shift_q [DEPTH];
   logic [CNT_W-1:0]        fill_q;
   logic                    order_q;
   logic                    out_valid_q;
   logic [DEPTH*WORD_W-1:0] out_data_q;
   logic [CNT_W-1:0]        out_words_q;
   logic                    frame_done_q;

   logic                    accept;
   logic                    slot_free;
   logic                    cur_msb;
   logic [CNT_W-1:0]        cnt_after;
   logic                    flush_go;
   logic                    xfer;
   logic [WORD_W-1:0]       word;
   logic [DEPTH*WORD_W-1:0] frame;

   assign in_ready  = (fill_q != Full);
   assign accept    = in_valid && in_ready;
   assign slot_free = !out_valid_q || out_ready;
   assign cnt_after = fill_q + CNT_W'(accept);
   // Order is latched on word 0; until then the live input decides.
   assign cur_msb   = (fill_q == '0) ? msb_first : order_q;

`ifdef SIPO_FLUSH_EN
   assign flush_go = flush && slot_free && (fill_q != '0);
`else
   assign flush_go = 1'b0;
`endif

   assign xfer = (slot_free && (cnt_after == Full)) || flush_go;

   // Assemble the outgoing frame, including a word accepted this cycle; unfilled slots stay zero.
   always_comb begin
      frame = '0;
      word  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         word = (accept && (fill_q == CNT_W'(i))) ? in_data : shift_q[i];
         if (CNT_W'(i) < cnt_after) begin
            if (cur_msb) begin
               frame[(DEPTH-1-i)*WORD_W +: WORD_W] = word;
            end else begin
               frame[i*WORD_W +: WORD_W] = word;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q       <= '0;
         order_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_words_q  <= '0;
         frame_done_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            shift_q[i] <= '0;
         end
      end else begin
         frame_done_q <= xfer;
         if (accept && (fill_q == '0)) begin
            order_q <= msb_first;
         end
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (accept && (fill_q == CNT_W'(i))) begin
               shift_q[i] <= in_data;
            end
         end
         if (xfer) begin
            out_data_q  <= frame;
            out_words_q <= cnt_after;
            out_valid_q <= 1'b1;
            fill_q      <= '0;
         end else begin
            fill_q <= cnt_after;
            if (out_ready) begin
               out_valid_q <= 1'b0;
            end
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_words  = out_words_q;
   assign fill_cnt   = fill_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sipo_stream_packer.sv
// Randomised bench for sipo_stream_packer (WORD_W=8, DEPTH=8) against a queue-based frame model,
// plus hand-computed frame checks.
module tb_sipo_stream_packer;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic        msb_first = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic [3:0]  out_words;
   logic [3:0]  fill_cnt;
   logic        frame_done;

   always #5 clk = ~clk;

   sipo_stream_packer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .msb_first  (msb_first),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_words  (out_words),
      .fill_cnt   (fill_cnt),
      .frame_done (frame_done)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Model: words pending in a queue, plus the frame sitting in the output register.
   logic [7:0]  m_q[$];
   bit          m_order;
   bit          m_valid;
   bit          m_done;
   logic [63:0] m_data;
   int          m_words;

   function automatic logic [63:0] pack(input logic [7:0] w[$], input bit msb);
      logic [63:0] f = '0;
      for (int i = 0; i < w.size(); i++) begin
         if (msb) f = (f << 8) | 64'(w[i]);
         else     f = f | (64'(w[i]) << (8 * i));
      end
      return f;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_step();
      bit rdy, acc, slot;
      if (rst) begin
         m_q.delete();
         m_valid = 0; m_done = 0; m_data = '0; m_words = 0; m_order = 0;
         return;
      end
      rdy  = (m_q.size() != D);
      acc  = in_valid && rdy;
      slot = !m_valid || out_ready;
      if (acc) begin
         if (m_q.size() == 0) m_order = msb_first;
         m_q.push_back(in_data);
      end
      if (m_q.size() == D && slot) begin
         m_data  = pack(m_q, m_order);
         m_words = D;
         m_valid = 1;
         m_done  = 1;
         m_q.delete();
      end else begin
         m_done = 0;
         if (out_ready) m_valid = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, (m_q.size() != D));
         chk("out_valid", out_valid, m_valid);
         chk("frame_done", frame_done, m_done);
         chk("fill_cnt", fill_cnt, m_q.size());
         chk("out_data", out_data, m_data);
         chk("out_words", out_words, m_words);
      end
   end

   logic [7:0]  rw [8];
   logic [63:0] exp_f;

   initial begin
      tick(); tick();
      rst    = 1'b0;
      chk_en = 1'b1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 64'h0);
      chk("rst_fill", fill_cnt, 4'd0);
      chk("rst_in_ready", in_ready, 1'b1);

      // Full frame, MSB-first, then LSB-first
      for (int pass = 0; pass < 2; pass++) begin
         out_ready = 1'b1;
         msb_first = (pass == 0);
         for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            tick();
            if (i == 6) chk("t1_no_early_valid", out_valid, 1'b0);
         end
         in_valid = 1'b0;
         chk("t1_done", frame_done, 1'b1);
         chk("t1_words", out_words, 4'd8);
         chk("t1_frame", out_data, (pass == 0) ? 64'h0102030405060708 : 64'h0807060504030201);
         tick();
         chk("t1_done_pulse", frame_done, 1'b0);
      end

      // Backpressure: 16 words with out_ready low
      out_ready = 1'b0;
      msb_first = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h10 + i);
         tick();
      end
      in_valid = 1'b0;
      chk("t3_held", out_data, 64'h1011121314151617);
      chk("t3_in_ready_low", in_ready, 1'b0);
      chk("t3_fill_full", fill_cnt, 4'd8);
      out_ready = 1'b1;
      tick();
      chk("t3_second", out_data, 64'h18191a1b1c1d1e1f);
      chk("t3_no_bubble", out_valid, 1'b1);
      chk("t3_in_ready_back", in_ready, 1'b1);
      tick();

      // Partial frame discarded by reset
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'hf0 + i);
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4_fill", fill_cnt, 4'd0);
      chk("t4_valid", out_valid, 1'b0);
      chk("t4_data", out_data, 64'h0);
      msb_first = 1'b0;
      exp_f = '0;
      for (int i = 0; i < 8; i++) begin
         rw[i]    = 8'($urandom);
         in_valid = 1'b1;
         in_data  = rw[i];
         exp_f    = exp_f | (64'(rw[i]) << (8 * i));
         tick();
      end
      in_valid = 1'b0;
      chk("t4_random_frame", out_data, exp_f);
      tick();

      // Order sampled at word 0 survives a mid-frame toggle
      msb_first = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) msb_first = 1'b0;
         in_valid = 1'b1;
         in_data  = 8'(8'h21 + i);
         tick();
      end
      in_valid = 1'b0;
      chk("t5_order_held", out_data, 64'h2122232425262728);
      tick();

      // Random traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         msb_first = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         tick();
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
